// File: rtl/mem_dump.sv
// Streams a contiguous range of RAM words out on a valid/ready interface,
// one synchronous RAM read per beat, never issuing a read while a beat is pending.
module mem_dump #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CAP,
    S_SEND,
    S_DONE
  } state_e;

  // A dump can never cover more than the whole address space.
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [ADDR_W:0]     remaining_q, remaining_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic                out_last_q, out_last_d;

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length != '0) begin
            cur_addr_d  = base_addr;
            remaining_d = (length > MAX_LEN) ? MAX_LEN : length;
            state_d     = S_REQ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_REQ: state_d = S_CAP;
      S_CAP: begin
        out_data_d = mem_rdata;
        out_addr_d = cur_addr_q;
        out_last_d = (remaining_q == ONE);
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (out_ready) begin
          if (remaining_q == ONE) begin
            state_d = S_DONE;
          end else begin
            cur_addr_d  = cur_addr_q + ADDR_W'(1);
            remaining_d = remaining_q - ONE;
            state_d     = S_REQ;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
    end
  end

  assign mem_re    = (state_q == S_REQ);
  assign mem_addr  = cur_addr_q;
  assign out_valid = (state_q == S_SEND);
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == S_REQ) || (state_q == S_CAP) || (state_q == S_SEND);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_mem_dump.sv
// Bench for mem_dump: directed scenarios plus randomized dumps checked cycle by
// cycle against a queue of expected beats and the 3-cycle-per-beat timing rule.
module tb_mem_dump;
  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [DEPTH];
  logic [3:0]    flags;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  mem_dump #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // RAM model: data valid only the cycle after a read strobe, junk otherwise.
  always @(posedge clk) mem_rdata <= mem_re ? mem[mem_addr] : DW'($urandom);

  assign flags = {busy, mem_re, out_valid, done};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"}, 64'(flags), 64'(0));
    check({tag, "_last"}, 64'(out_last), 64'(0));
    check({tag, "_data"}, 64'(out_data), 64'(0));
    check({tag, "_oaddr"}, 64'(out_addr), 64'(0));
    check({tag, "_maddr"}, 64'(mem_addr), 64'(0));
  endtask

  // Caller must be at a falling edge with the DUT idle. abort_after>0 pulls
  // rst low right after that many beats have been accepted.
  task automatic run_dump(input logic [AW-1:0] base, input logic [AW:0] len,
                          input int ready_pct, input int stall_beat,
                          input int stall_len, input int abort_after);
    int   k, next_k, done_k, popped, stalled, n;
    logic rdy, ev, er;
    logic [3:0] ef;
    beat_t front;

    exp_q.delete();
    n = (int'(len) > DEPTH) ? DEPTH : int'(len);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.addr = AW'(int'(base) + i);
      b.data = mem[b.addr];
      b.last = (i == n - 1);
      exp_q.push_back(b);
    end

    start     = 1'b1;
    base_addr = base;
    length    = len;
    out_ready = 1'b1;
    check("start_idle_flags", 64'(flags), 64'(0));

    next_k  = 3;
    done_k  = (n == 0) ? 1 : -1;
    popped  = 0;
    stalled = 0;
    k       = 0;
    while (1) begin
      @(negedge clk);
      k++;
      if (abort_after > 0 && popped == abort_after) begin
        rst   = 1'b0;
        start = 1'b0;
        return;
      end
      ev = (exp_q.size() > 0) && (k >= next_k);
      er = (exp_q.size() > 0) && (k == next_k - 2);
      ef = {exp_q.size() > 0, er, ev, k == done_k};
      check("flags", 64'(flags), 64'(ef));
      if (exp_q.size() > 0) front = exp_q[0];
      if (ev) begin
        check("out_data", 64'(out_data), 64'(front.data));
        check("out_addr", 64'(out_addr), 64'(front.addr));
        check("out_last", 64'(out_last), 64'(front.last));
      end
      if (er) check("mem_addr", 64'(mem_addr), 64'(front.addr));

      // Requests arriving mid-dump must be ignored.
      if (exp_q.size() > 0) begin
        start     = ($urandom_range(3) == 0);
        base_addr = AW'($urandom);
        length    = (AW + 1)'($urandom);
      end else begin
        start = 1'b0;
      end

      if (ev && popped == stall_beat && stalled < stall_len) begin
        rdy = 1'b0;
        stalled++;
      end else begin
        rdy = ($urandom_range(99) < ready_pct);
      end
      out_ready = rdy;

      if (ev && rdy) begin
        void'(exp_q.pop_front());
        popped++;
        next_k = k + 3;
        if (exp_q.size() == 0) done_k = k + 1;
      end
      if (k == done_k) break;
      if (k > 4000) begin
        check("cycle_budget", 64'(k), 64'(4000));
        break;
      end
    end
    start = 1'b0;
    @(negedge clk);
    check("post_done_flags", 64'(flags), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(32'h100 + i);
    rst       = 1'b0;
    start     = 1'b1;
    base_addr = AW'($urandom);
    length    = (AW + 1)'($urandom);
    out_ready = 1'b1;

    repeat (3) begin
      @(negedge clk);
      check_all_zero("reset");
      start     = $urandom_range(1) == 1;
      base_addr = AW'($urandom);
      length    = (AW + 1)'($urandom);
      out_ready = $urandom_range(1) == 1;
    end
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);

    run_dump(8'h00, 9'd4, 100, -1, 0, 0);
    run_dump(8'h00, 9'd4, 100, 1, 5, 0);
    run_dump(8'hFE, 9'd3, 100, -1, 0, 0);
    run_dump(8'h00, 9'd0, 100, -1, 0, 0);

    run_dump(8'h00, 9'd8, 100, -1, 0, 2);
    @(negedge clk);
    check_all_zero("abort");
    rst = 1'b1;
    run_dump(8'h10, 9'd1, 100, -1, 0, 0);

    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    run_dump(8'hC3, 9'd300, 100, -1, 0, 0);
    for (int t = 0; t < 20; t++) begin
      run_dump(AW'($urandom), (AW + 1)'($urandom_range(20)),
               $urandom_range(100, 30), $urandom_range(3), $urandom_range(4), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
